// File: rtl/block_dispatcher.sv
// block_dispatcher: hands out thread-block indices to idle cores and signals kernel completion.
module block_dispatcher #(
  parameter int NUM_CORES = 2,
  parameter int DATA_W    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          launch,
  input  logic [DATA_W-1:0]             num_blocks,
  input  logic [DATA_W-1:0]             block_dim_in,
  output logic                          busy,
  output logic                          kernel_done,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [NUM_CORES*DATA_W-1:0]   core_block_idx,
  output logic [DATA_W-1:0]             core_block_dim,
  output logic [NUM_CORES-1:0]          core_busy,
  input  logic [NUM_CORES-1:0]          core_done
);
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] nb_r, next_block, done_count, done_pop, done_next;
  logic [NUM_CORES-1:0] done_mask, pick;
  logic active;
  always_comb begin
    active = state == DISPATCH || state == DRAIN;
    done_mask = active ? core_done & core_busy : '0;
    // isolate the lowest clear bit of the registered busy vector; zero when all cores are occupied
    pick = state == DISPATCH ? ~core_busy & (core_busy + NUM_CORES'(1)) : '0;
    done_pop = '0;
    for (int i = 0; i < NUM_CORES; i++) done_pop = done_pop + DATA_W'(done_mask[i]);
    done_next = done_count + done_pop;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      nb_r <= '0;
      next_block <= '0;
      done_count <= '0;
      busy <= 1'b0;
      kernel_done <= 1'b0;
      core_start <= '0;
      core_block_idx <= '0;
      core_block_dim <= '0;
      core_busy <= '0;
    end else begin
      kernel_done <= state == DONE;
      busy <= active;
      core_start <= pick;
      core_busy <= (core_busy & ~done_mask) | pick;
      done_count <= done_next;
      for (int i = 0; i < NUM_CORES; i++)
        if (pick[i]) core_block_idx[i*DATA_W +: DATA_W] <= next_block;
      if (|pick) next_block <= next_block + DATA_W'(1);
      case (state)
        IDLE: if (launch) begin
          nb_r <= num_blocks;
          core_block_dim <= block_dim_in;
          next_block <= '0;
          done_count <= '0;
          state <= num_blocks == '0 ? DONE : DISPATCH;
        end
        DISPATCH: if (|pick && next_block + DATA_W'(1) == nb_r) state <= DRAIN;
        DRAIN: if (done_next == nb_r) state <= DONE;
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_block_dispatcher.sv
// tb_block_dispatcher: table-driven, directed and randomized checks of block_dispatcher against a behavioural model.
module tb_block_dispatcher;
  localparam int NC = 2;
  localparam int DW = 16;
  localparam int P_IDLE = 0, P_DISP = 1, P_DRAIN = 2, P_DONE = 3;
  logic clk = 0, reset = 0, launch = 0;
  logic [DW-1:0] num_blocks = 0, block_dim_in = 0;
  logic busy, kernel_done;
  logic [NC-1:0] core_start, core_busy, core_done = 0;
  logic [NC*DW-1:0] core_block_idx;
  logic [DW-1:0] core_block_dim;
  int checks = 0, errors = 0;

  block_dispatcher #(.NUM_CORES(NC), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .launch(launch), .num_blocks(num_blocks),
    .block_dim_in(block_dim_in), .busy(busy), .kernel_done(kernel_done),
    .core_start(core_start), .core_block_idx(core_block_idx),
    .core_block_dim(core_block_dim), .core_busy(core_busy), .core_done(core_done));

  always #5 clk = ~clk;

  // behavioural model: phase, issued/retired counts, per-core occupancy and held indices
  int m_ph, m_nb, m_issued, m_retired;
  bit m_occ[NC];
  logic [DW-1:0] m_idx[NC];
  logic [DW-1:0] m_dim;
  logic [NC-1:0] e_start;
  bit e_busy, e_kd;

  function automatic logic [NC-1:0] occ_vec();
    logic [NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i] = m_occ[i];
    return v;
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; m_nb = 0; m_issued = 0; m_retired = 0; m_dim = 0;
    e_start = 0; e_busy = 0; e_kd = 0;
    for (int i = 0; i < NC; i++) begin m_occ[i] = 0; m_idx[i] = 0; end
  endtask

  task automatic model_step();
    bit was_occ[NC];
    int ph0;
    ph0 = m_ph;
    e_kd = ph0 == P_DONE;
    e_busy = ph0 == P_DISP || ph0 == P_DRAIN;
    e_start = 0;
    if (ph0 == P_IDLE) begin
      if (launch) begin
        m_nb = int'(num_blocks); m_dim = block_dim_in; m_issued = 0; m_retired = 0;
        m_ph = num_blocks == 0 ? P_DONE : P_DISP;
      end
    end else if (ph0 == P_DONE) m_ph = P_IDLE;
    else begin
      for (int i = 0; i < NC; i++) was_occ[i] = m_occ[i];
      for (int i = 0; i < NC; i++)
        if (core_done[i] && was_occ[i]) begin m_occ[i] = 0; m_retired++; end
      if (ph0 == P_DISP) begin
        for (int i = 0; i < NC; i++)
          if (!was_occ[i]) begin
            e_start[i] = 1; m_idx[i] = DW'(m_issued); m_occ[i] = 1; m_issued++;
            if (m_issued == m_nb) m_ph = P_DRAIN;
            break;
          end
      end else if (m_retired == m_nb) m_ph = P_DONE;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit l, input logic [DW-1:0] n, input logic [DW-1:0] b, input logic [NC-1:0] d);
    launch = l; num_blocks = n; block_dim_in = b; core_done = d;
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("start", core_start, e_start);
    chk("busy", busy, e_busy);
    chk("kernel_done", kernel_done, e_kd);
    chk("core_busy", core_busy, occ_vec());
    chk("block_dim", core_block_dim, m_dim);
    for (int i = 0; i < NC; i++) chk("block_idx", core_block_idx[i*DW +: DW], m_idx[i]);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_kd"}, kernel_done, 0);
    chk({name, "_start"}, core_start, 0);
    chk({name, "_idx"}, core_block_idx, 0);
    chk({name, "_dim"}, core_block_dim, 0);
    chk({name, "_cbusy"}, core_busy, 0);
  endtask

  typedef struct {
    bit l; logic [DW-1:0] n; logic [DW-1:0] b; logic [1:0] d;
    logic [1:0] s; bit bz; bit kd; logic [1:0] cb; logic [DW-1:0] ix;
  } vec_t;
  vec_t tbl[15];

  initial begin
    // 5 blocks, each core retires 3 edges after its start
    tbl[0]  = '{1, 5, 8, 2'b00, 2'b00, 0, 0, 2'b00, 0};
    tbl[1]  = '{0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b01, 0};
    tbl[2]  = '{0, 0, 0, 2'b00, 2'b10, 1, 0, 2'b11, 1};
    tbl[3]  = '{0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b11, 0};
    tbl[4]  = '{0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b10, 0};
    tbl[5]  = '{0, 0, 0, 2'b10, 2'b01, 1, 0, 2'b01, 2};
    tbl[6]  = '{0, 0, 0, 2'b00, 2'b10, 1, 0, 2'b11, 3};
    tbl[7]  = '{0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b11, 0};
    tbl[8]  = '{0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b10, 0};
    tbl[9]  = '{0, 0, 0, 2'b10, 2'b01, 1, 0, 2'b01, 4};
    tbl[10] = '{0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b01, 0};
    tbl[11] = '{0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b01, 0};
    tbl[12] = '{0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 0};
    tbl[13] = '{0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 0};
    tbl[14] = '{0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0};
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1;
    @(negedge clk);

    for (int k = 0; k < 15; k++) begin
      cyc(tbl[k].l, tbl[k].n, tbl[k].b, tbl[k].d);
      chk("tbl_start", core_start, tbl[k].s);
      chk("tbl_busy", busy, tbl[k].bz);
      chk("tbl_kd", kernel_done, tbl[k].kd);
      chk("tbl_cbusy", core_busy, tbl[k].cb);
      chk("tbl_dim", core_block_dim, 8);
      if (tbl[k].s != 0) chk("tbl_idx", core_block_idx[(tbl[k].s[1] ? DW : 0) +: DW], tbl[k].ix);
    end

    // empty grid: done two edges after launch, no starts, never busy
    cyc(1, 0, 3, 0);
    chk("zero_kd0", kernel_done, 0);
    cyc(0, 0, 0, 0);
    chk("zero_kd1", kernel_done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_start", core_start, 0);
    cyc(0, 0, 0, 0);
    chk("zero_kd2", kernel_done, 0);

    // simultaneous completions on both cores
    cyc(1, 4, 2, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 2'b11);
    chk("simul_cbusy", core_busy, 2'b00);
    cyc(0, 0, 0, 0);
    chk("simul_start0", core_start, 2'b01);
    chk("simul_idx0", core_block_idx[0 +: DW], 2);
    cyc(0, 0, 0, 0);
    chk("simul_start1", core_start, 2'b10);
    chk("simul_idx1", core_block_idx[DW +: DW], 3);
    cyc(0, 0, 0, 2'b11);
    cyc(0, 0, 0, 0);
    chk("simul_kd", kernel_done, 1);

    // launch and done on an idle core during a running kernel are ignored
    cyc(1, 3, 5, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 2'b01);
    cyc(1, 9, 7, 2'b01);
    chk("ign_dim", core_block_dim, 5);
    chk("ign_idx", core_block_idx[0 +: DW], 2);
    cyc(0, 0, 0, 2'b10);
    chk("ign_kd_early", kernel_done, 0);
    cyc(0, 0, 0, 2'b01);
    cyc(0, 0, 0, 0);
    chk("ign_kd", kernel_done, 1);

    // reset mid-dispatch abandons the kernel
    cyc(1, 5, 4, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    reset = 0;
    #1;
    chk_zero("midreset");
    model_reset();
    @(negedge clk);
    reset = 1;
    repeat (4) begin
      cyc(0, 0, 0, 0);
      chk("post_reset_kd", kernel_done, 0);
    end
    cyc(1, 1, 6, 0);
    cyc(0, 0, 0, 0);
    chk("post_reset_start", core_start, 2'b01);
    chk("post_reset_idx", core_block_idx[0 +: DW], 0);
    cyc(0, 0, 0, 2'b01);
    cyc(0, 0, 0, 0);
    chk("post_reset_kd1", kernel_done, 1);
    cyc(0, 0, 0, 0);

    // randomized kernels with stray launches and stray completions
    for (int k = 0; k < 40; k++) begin
      int g;
      logic [NC-1:0] d;
      repeat ($urandom_range(0, 3)) cyc(0, DW'($urandom), DW'($urandom), NC'($urandom));
      cyc(1, ($urandom % 8 == 0) ? 0 : DW'($urandom_range(1, 12)), DW'($urandom), 0);
      g = 0;
      while (m_ph != P_IDLE && g < 400) begin
        for (int i = 0; i < NC; i++)
          d[i] = m_occ[i] ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
        cyc($urandom % 6 == 0, DW'($urandom), DW'($urandom), d);
        g++;
      end
      chk("rand_timeout", g < 400, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
